// File: rtl/scramble_loader.sv
// Pseudo-random load sequencer for the Scrambled Number SUM game: draws NUM_COUNT
// nibbles from a free-running LFSR, strobes each into its load register and sums them.
module scramble_loader #(
  parameter int         NUM_COUNT = 4,
  parameter logic [7:0] SEED      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] data_out,
  output logic       ld,
  output logic [1:0] sel,
  output logic [5:0] sum,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] LAST_IDX = 2'(NUM_COUNT - 1);

  state_t     state, state_nxt;
  logic [7:0] lfsr;
  logic [1:0] idx;
  logic       feedback;

  assign feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  // The LFSR never pauses, so the cycle on which start arrives picks the sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[6:0], feedback};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: state_nxt = (idx == LAST_IDX) ? DONE : GAP;
      GAP:  state_nxt = LOAD;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // data_out/sel only change on entry to LOAD, so they are stable while ld is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= 2'd0;
      data_out <= 4'd0;
      sel      <= 2'd0;
      sum      <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx      <= 2'd0;
            sum      <= 6'd0;
            data_out <= lfsr[3:0];
            sel      <= 2'd0;
          end
        end
        LOAD: begin
          sum <= sum + {2'b00, data_out};
          if (idx != LAST_IDX) begin
            idx <= idx + 2'd1;
          end
        end
        GAP: begin
          data_out <= lfsr[3:0];
          sel      <= idx;
        end
        default: begin
        end
      endcase
    end
  end

  assign ld   = (state == LOAD);
  assign done = (state == DONE);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_scramble_loader.sv
// Self-checking bench for scramble_loader: directed rounds plus random start timing,
// checked cycle by cycle against a free-running LFSR model and a round-level scoreboard.
module tb_scramble_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] start_vec = 3'b000;

  logic [3:0] data_o [3];
  logic       ld_o   [3];
  logic [1:0] sel_o  [3];
  logic [5:0] sum_o  [3];
  logic       busy_o [3];
  logic       done_o [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_a5, m_01;
  logic [5:0] total;
  logic [15:0] vpk;

  always #5 clk = ~clk;

  // Instance 0: nominal, 1: single value per round, 2: alternate seed
  scramble_loader #(.NUM_COUNT(4), .SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start_vec[0]), .data_out(data_o[0]), .ld(ld_o[0]),
    .sel(sel_o[0]), .sum(sum_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  scramble_loader #(.NUM_COUNT(1), .SEED(8'hA5)) dut_n1 (
    .clk(clk), .rst(rst), .start(start_vec[1]), .data_out(data_o[1]), .ld(ld_o[1]),
    .sel(sel_o[1]), .sum(sum_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  scramble_loader #(.NUM_COUNT(4), .SEED(8'h01)) dut_s1 (
    .clk(clk), .rst(rst), .start(start_vec[2]), .data_out(data_o[2]), .ld(ld_o[2]),
    .sel(sel_o[2]), .sum(sum_o[2]), .busy(busy_o[2]), .done(done_o[2]));

  // Feedback is the parity of taps 7,5,4,3 (mask B8), shifted in at the bottom.
  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], ^(q & 8'hB8)};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_a5 <= 8'hA5;
      m_01 <= 8'h01;
    end else begin
      m_a5 <= lfsr_step(m_a5);
      m_01 <= lfsr_step(m_01);
    end
  end

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input int w, input string tag);
    check_output($sformatf("%s_ld%0d", tag, w),   {7'd0, ld_o[w]},   8'd0);
    check_output($sformatf("%s_data%0d", tag, w), {4'd0, data_o[w]}, 8'd0);
    check_output($sformatf("%s_sel%0d", tag, w),  {6'd0, sel_o[w]},  8'd0);
    check_output($sformatf("%s_sum%0d", tag, w),  {2'd0, sum_o[w]},  8'd0);
    check_output($sformatf("%s_busy%0d", tag, w), {7'd0, busy_o[w]}, 8'd0);
    check_output($sformatf("%s_done%0d", tag, w), {7'd0, done_o[w]}, 8'd0);
  endtask

  // Entered at a falling edge in the cycle before the start edge. Walks the round
  // cycle by cycle; the scoreboard records the model LFSR nibble at each draw point.
  task automatic apply_stimulus(input int w, input int n, input logic [15:0] mask,
                                input bit hold, output logic [5:0] tot,
                                output logic [15:0] packed_vals);
    logic [3:0] vals [4];
    logic [5:0] esum;
    int j, loads;
    for (int i = 0; i < 4; i++) vals[i] = 4'd0;
    esum = 6'd0;
    vals[0] = (w == 2) ? m_01[3:0] : m_a5[3:0];
    start_vec[w] = 1'b1;
    for (int k = 1; k <= 2 * n + 1; k++) begin
      @(negedge clk);
      j = (k - 1) / 2;
      if (j > n - 1) j = n - 1;
      loads = k / 2;
      if (loads > n) loads = n;
      esum = 6'd0;
      for (int i = 0; i < loads; i++) esum = esum + {2'b00, vals[i]};
      check_output($sformatf("ld_w%0d_c%0d", w, k), {7'd0, ld_o[w]},
                   {7'd0, ((k % 2) == 1) && (k <= 2 * n - 1)});
      check_output($sformatf("done_w%0d_c%0d", w, k), {7'd0, done_o[w]}, {7'd0, k == 2 * n});
      check_output($sformatf("busy_w%0d_c%0d", w, k), {7'd0, busy_o[w]}, {7'd0, k <= 2 * n});
      check_output($sformatf("data_w%0d_c%0d", w, k), {4'd0, data_o[w]}, {4'd0, vals[j]});
      check_output($sformatf("sel_w%0d_c%0d", w, k), {6'd0, sel_o[w]}, 8'(j));
      check_output($sformatf("sum_w%0d_c%0d", w, k), {2'd0, sum_o[w]}, {2'd0, esum});
      if ((k % 2) == 0 && (k / 2) < n) begin
        vals[k / 2] = (w == 2) ? m_01[3:0] : m_a5[3:0];
      end
      start_vec[w] = (k <= 2 * n) ? (hold | mask[k]) : hold;
    end
    tot = esum;
    packed_vals = {vals[3], vals[2], vals[1], vals[0]};
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Reset held while start toggles: everything stays zero, no ld.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start_vec = (c % 2 == 0) ? 3'b111 : 3'b000;
      for (int w = 0; w < 3; w++) check_all_zero(w, "rst_hold");
    end
    start_vec = 3'b000;

    // Nominal round from SEED with start pulses while busy (cycles 2, 5, 8).
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(0, 4, 16'h0124, 1'b0, total, vpk);
    check_output("nominal_sum", {2'd0, total}, 8'h11);
    check_output("nominal_vals_lo", vpk[7:0], 8'h55);
    check_output("nominal_vals_hi", vpk[15:8], 8'h34);

    // Continuous start across two rounds.
    apply_stimulus(0, 4, 16'h0000, 1'b1, total, vpk);
    apply_stimulus(0, 4, 16'h0000, 1'b0, total, vpk);

    // Random idle gaps and random start noise while busy.
    for (int r = 0; r < 6; r++) begin
      int gap;
      gap = $urandom_range(0, 4);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check_output($sformatf("idle_ld_r%0d", r), {7'd0, ld_o[0]}, 8'd0);
        check_output($sformatf("idle_busy_r%0d", r), {7'd0, busy_o[0]}, 8'd0);
      end
      apply_stimulus(0, 4, 16'($urandom) & 16'h01FE, 1'b0, total, vpk);
    end

    // Reset during the second LOAD cycle.
    @(negedge clk);
    start_vec[0] = 1'b1;
    @(negedge clk);
    start_vec[0] = 1'b0;
    repeat (2) @(negedge clk);
    check_output("midrst_pre_ld", {7'd0, ld_o[0]}, 8'd1);
    rst = 1'b0;
    #1;
    check_all_zero(0, "midrst");
    repeat (2) @(negedge clk);
    check_all_zero(0, "midrst_hold");
    rst = 1'b1;
    apply_stimulus(0, 4, 16'h0000, 1'b0, total, vpk);
    check_output("midrst_restart_sum", {2'd0, total}, 8'h11);
    check_output("midrst_restart_vals", vpk[7:0], 8'h55);

    // Single-value rounds.
    reset_pulse();
    apply_stimulus(1, 1, 16'h0000, 1'b0, total, vpk);
    check_output("n1_sum", {2'd0, total}, 8'd5);
    check_output("n1_vals", vpk[7:0], 8'h05);
    apply_stimulus(1, 1, 16'h0002, 1'b1, total, vpk);
    apply_stimulus(1, 1, 16'h0000, 1'b0, total, vpk);

    // Alternate seed.
    reset_pulse();
    apply_stimulus(2, 4, 16'h0000, 1'b0, total, vpk);
    repeat (3) @(negedge clk);
    apply_stimulus(2, 4, 16'($urandom) & 16'h01FE, 1'b0, total, vpk);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
